// File: rtl/decodificador_morse.sv
// Morse digit decoder: collects five dot/dash symbols over a valid/ready handshake and
// holds the BCD digit until acknowledged. Define DECODIFICADOR_TIMEOUT_EN for the idle timeout.
module decodificador_morse #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic sym_valid,
   input  logic sym,
   output logic sym_ready,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic ready,
   input  logic ack,
   output logic erro,
   output logic timeout
);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [4:0]  p, p_nxt;
   logic        xfer, last, expire;
   logic [3:0]  dec_digit;
   logic        dec_err;

   assign sym_ready = (state != DONE);
   assign ready     = (state == DONE);
   assign xfer      = sym_valid && sym_ready;
   assign last      = xfer && (cnt == 3'd4);

   // p[0] is the first symbol received; p_nxt includes the symbol arriving this cycle
   always_comb begin
      p_nxt = p;
      for (int i = 0; i < 5; i++)
         if (xfer && cnt == 3'(i)) p_nxt[i] = sym;
   end

   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (no latch).
      dec_digit = 4'hF;
      dec_err   = 1'b0;
      case (p_nxt)
         5'b11111: dec_digit = 4'd0;
         5'b11110: dec_digit = 4'd1;
         5'b11100: dec_digit = 4'd2;
         5'b11000: dec_digit = 4'd3;
         5'b10000: dec_digit = 4'd4;
         5'b00000: dec_digit = 4'd5;
         5'b00001: dec_digit = 4'd6;
         5'b00011: dec_digit = 4'd7;
         5'b00111: dec_digit = 4'd8;
         5'b01111: dec_digit = 4'd9;
         default:  dec_err   = 1'b1;
      endcase
   end

`ifdef DECODIFICADOR_TIMEOUT_EN
   logic [7:0] idle_cnt;

   assign expire = (state == RECV) && !xfer && (idle_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt <= 8'd0;
         timeout  <= 1'b0;
      end else begin
         if (state != RECV || xfer) idle_cnt <= 8'd0;
         else                       idle_cnt <= idle_cnt + 8'd1;
         timeout <= expire;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^8'(TIMEOUT);
   assign expire         = 1'b0;
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer) state_nxt = RECV;
         RECV:    if (last) state_nxt = DONE;
                  else if (expire) state_nxt = IDLE;
         DONE:    if (ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt          <= 3'd0;
         p            <= 5'd0;
         {a, b, c, d} <= 4'd0;
         erro         <= 1'b0;
      end else if (state == DONE && ack) begin
         cnt <= 3'd0;
      end else if (expire) begin
         cnt <= 3'd0;
         p   <= 5'd0;
      end else if (xfer) begin
         cnt <= cnt + 3'd1;
         p   <= p_nxt;
         if (last) begin
            {a, b, c, d} <= dec_digit;
            erro         <= dec_err;
         end
      end
   end

endmodule

// File: tb/tb_decodificador_morse.sv
// Self-checking bench for decodificador_morse: directed digit/error/backpressure/reset/timeout
// scenarios plus random traffic, all compared against a queue-based reference model.
module tb_decodificador_morse;

`ifdef DECODIFICADOR_TIMEOUT_EN
   localparam int TO    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 15;
   localparam bit TO_EN = 1'b0;
`endif

   logic clk, reset, sym_valid, sym, sym_ready;
   logic a, b, c, d, ready, ack, erro, timeout;

   decodificador_morse #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym),
      .sym_ready(sym_ready), .a(a), .b(b), .c(c), .d(d),
      .ready(ready), .ack(ack), .erro(erro), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   bit         m_q[$];
   bit         m_done, m_erro, m_to;
   logic [3:0] m_digit;
   int         m_idle;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Digit from the rule "leading run of k equal symbols, then only the opposite symbol"
   function automatic void decode_ref(input bit s[5], output logic [3:0] dg, output bit er);
      int k = 1;
      while (k < 5 && s[k] == s[0]) k++;
      er = 1'b0;
      for (int i = k; i < 5; i++) if (s[i] == s[0]) er = 1'b1;
      if (er)            dg = 4'hF;
      else if (s[0] == 0) dg = 4'((k == 5) ? 5 : k);
      else               dg = 4'((k == 5) ? 0 : 5 + k);
   endfunction

   function automatic logic [4:0] pat_of(input int dg);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) begin
         if (dg == 0)      r[i] = 1'b1;
         else if (dg <= 4) r[i] = (i >= dg);
         else if (dg == 5) r[i] = 1'b0;
         else              r[i] = (i < dg - 5);
      end
      return r;
   endfunction

   task automatic model_update(input bit v, input bit s, input bit k);
      bit arr[5];
      m_to = 1'b0;
      if (m_done) begin
         if (k) m_done = 1'b0;
      end else if (v) begin
         m_q.push_back(s);
         m_idle = 0;
         if (m_q.size() == 5) begin
            for (int i = 0; i < 5; i++) arr[i] = m_q[i];
            decode_ref(arr, m_digit, m_erro);
            m_done = 1'b1;
            m_q.delete();
         end
      end else if (TO_EN && m_q.size() > 0) begin
         m_idle++;
         if (m_idle == TO) begin
            m_q.delete();
            m_idle = 0;
            m_to   = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check("sym_ready", 8'(sym_ready), 8'(!m_done));
      check("ready", 8'(ready), 8'(m_done));
      check("digit", 8'({a, b, c, d}), 8'(m_digit));
      check("erro", 8'(erro), 8'(m_erro));
      check("timeout", 8'(timeout), 8'(m_to));
   endtask

   task automatic tick();
      bit v, s, k;
      v = sym_valid;
      s = sym;
      k = ack;
      @(posedge clk);
      model_update(v, s, k);
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #2;
      check("rst_ready", 8'(ready), 8'd0);
      check("rst_sym_ready", 8'(sym_ready), 8'd1);
      check("rst_digit", 8'({a, b, c, d}), 8'd0);
      check("rst_erro", 8'(erro), 8'd0);
      check("rst_timeout", 8'(timeout), 8'd0);
      m_q.delete();
      m_done  = 1'b0;
      m_erro  = 1'b0;
      m_to    = 1'b0;
      m_digit = 4'd0;
      m_idle  = 0;
      #2;
      reset = 1'b1;
   endtask

   task automatic send(input bit s);
      sym_valid = 1'b1;
      sym       = s;
      tick();
      sym_valid = 1'b0;
   endtask

   task automatic send_pat(input logic [4:0] pt);
      for (int i = 0; i < 5; i++) send(pt[i]);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   int pulses;

   initial begin
      reset = 1'b0; sym_valid = 1'b0; sym = 1'b0; ack = 1'b0;
      #1;
      apply_reset();
      tick();

      // every legal digit, then ack; digit stays on a..d after ack
      for (int dg = 0; dg < 10; dg++) begin
         send_pat(pat_of(dg));
         check("dig_ready", 8'(ready), 8'd1);
         check("dig_val", 8'({a, b, c, d}), 8'(dg));
         check("dig_erro", 8'(erro), 8'd0);
         do_ack();
         check("ack_clears_ready", 8'(ready), 8'd0);
         check("held_after_ack", 8'({a, b, c, d}), 8'(dg));
      end

      // illegal pattern dot,dash,dot,dash,dot
      send_pat(5'b01010);
      check("err_ready", 8'(ready), 8'd1);
      check("err_flag", 8'(erro), 8'd1);
      check("err_digit", 8'({a, b, c, d}), 8'hF);
      do_ack();

      // backpressure: valid held while result is pending
      send_pat(pat_of(3));
      sym_valid = 1'b1;
      sym       = 1'b1;
      repeat (10) begin
         tick();
         check("bp_sym_ready", 8'(sym_ready), 8'd0);
         check("bp_digit", 8'({a, b, c, d}), 8'd3);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (4) tick();
      check("bp_not_yet", 8'(ready), 8'd0);
      tick();
      sym_valid = 1'b0;
      check("bp_ready", 8'(ready), 8'd1);
      check("bp_digit0", 8'({a, b, c, d}), 8'd0);
      do_ack();

      // reset mid-character discards partial symbols
      send(1'b1); send(1'b0); send(1'b1);
      apply_reset();
      send_pat(pat_of(7));
      check("rst_then7", 8'({a, b, c, d}), 8'd7);
      check("rst_then7_rdy", 8'(ready), 8'd1);
      do_ack();

`ifdef DECODIFICADOR_TIMEOUT_EN
      send(1'b0); send(1'b1);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (timeout) pulses++;
      end
      check("to_on_4th", 8'(timeout), 8'd1);
      tick();
      check("to_one_cycle", 8'(timeout), 8'd0);
      check("to_pulses", 8'(pulses), 8'd1);
      send_pat(pat_of(0));
      check("to_then0", 8'({a, b, c, d}), 8'd0);
      check("to_then0_rdy", 8'(ready), 8'd1);
      do_ack();

      send(1'b0); send(1'b0);
      pulses = 0;
      repeat (3) begin
         tick();
         if (timeout) pulses++;
      end
      send(1'b1);
      if (timeout) pulses++;
      send(1'b1);
      if (timeout) pulses++;
      send(1'b1);
      check("win_pulses", 8'(pulses), 8'd0);
      check("win_digit", 8'({a, b, c, d}), 8'd2);
      check("win_ready", 8'(ready), 8'd1);
      do_ack();
`else
      send(1'b0); send(1'b1);
      pulses = 0;
      repeat (40) begin
         tick();
         if (timeout) pulses++;
      end
      check("no_to_pulses", 8'(pulses), 8'd0);
      send(1'b1); send(1'b1); send(1'b1);
      check("held_partial", 8'({a, b, c, d}), 8'd1);
      check("held_partial_rdy", 8'(ready), 8'd1);
      do_ack();
`endif

      // random traffic against the model
      repeat (400) begin
         sym_valid = ($urandom_range(0, 99) < 60);
         sym       = 1'($urandom_range(0, 1));
         ack       = ($urandom_range(0, 3) == 0);
         tick();
      end
      sym_valid = 1'b0;
      ack       = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decodificador_morse.md
DECODIFICADOR_MORSE -- requirements
Module: decodificador_morse

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: number of idle clock cycles allowed between symbols of one character; legal range 2..255; used only when DECODIFICADOR_TIMEOUT_EN is defined.
REQ-002 SHALL have port: clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port: sym_valid, input, 1, a symbol is offered on sym this cycle.
REQ-005 SHALL have port: sym, input, 1, Morse symbol: 0 = dot, 1 = dash.
REQ-006 SHALL have port: sym_ready, output, 1, the decoder can accept a symbol this cycle.
REQ-007 SHALL have ports: a, b, c, d, output, 1 each, decoded digit in BCD; a is MSB, d is LSB.
REQ-008 SHALL have port: ready, output, 1, the digit on a..d and erro is valid and held.
REQ-009 SHALL have port: ack, input, 1, the consumer takes the digit.
REQ-010 SHALL have port: erro, output, 1, the held result is not a legal digit pattern.
REQ-011 SHALL have port: timeout, output, 1, one-cycle pulse when a partial character is discarded.

Function
REQ-012 SHALL transfer a symbol on every rising edge where sym_valid and sym_ready are both 1; sym_valid with sym_ready = 0 SHALL have no effect.
REQ-013 SHALL implement states IDLE (0 symbols held), RECV (1..4 symbols held) and DONE (result held).
REQ-014 SHALL assert sym_ready = 1 in IDLE and RECV and sym_ready = 0 in DONE.
REQ-015 SHALL store symbols in arrival order as p1..p5 and count them with a 3-bit counter.
REQ-016 The transfer that moves the counter from 0 to 1 SHALL change the state from IDLE to RECV.
REQ-017 On the fifth transfer, the block SHALL decode, load a..d and erro, and enter DONE; ready SHALL be 1 on the next cycle (latency 1 cycle from the fifth accepted symbol).
REQ-018 SHALL decode p1..p5 as follows: k leading dots followed by dashes (k = 1..4) -> digit k; five dots -> 5; k leading dashes followed by dots (k = 1..4) -> digit 5+k; five dashes -> 0.
REQ-019 For any other pattern, the block SHALL set erro = 1 and a,b,c,d = 1111.
REQ-020 For a legal pattern, the block SHALL set erro = 0.
REQ-021 In DONE, ready, a..d and erro SHALL stay stable until an ack is sampled high.
REQ-022 On the ack cycle, the block SHALL clear ready, clear the counter and go to IDLE.
REQ-023 ack while ready = 0 SHALL be ignored.
REQ-024 ready and ack high together with sym_valid SHALL NOT accept the symbol in that cycle, because sym_ready = 0; the symbol is accepted from the next cycle.
REQ-025 a..d and erro SHALL keep their last value after ack until the next decode.

Reset
REQ-026 When reset = 0, the block SHALL immediately force: state IDLE, counter 0, p1..p5 = 0, a,b,c,d = 0, ready = 0, erro = 0, timeout = 0, and sym_ready = 1 after release.
REQ-027 Reset asserted mid-character or in DONE SHALL discard all partial or held data without any timeout pulse.

Configuration
REQ-028 With macro DECODIFICADOR_TIMEOUT_EN defined, the block SHALL implement an 8-bit idle counter that counts only in RECV and clears on every accepted symbol.
REQ-029 With DECODIFICADOR_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT, the block SHALL discard the partial character, return to IDLE and pulse timeout for exactly one cycle.
REQ-030 With DECODIFICADOR_TIMEOUT_EN defined, a symbol accepted in the expiry cycle SHALL win: the counter clears, there is no timeout, and the symbol is stored.
REQ-031 With DECODIFICADOR_TIMEOUT_EN undefined, timeout SHALL be tied to 0, there SHALL be no idle counter, and a partial character SHALL be held indefinitely.

Verification
REQ-032 The bench SHALL cover: for each digit 0..9, feed its five-symbol pattern, then ack -> ready after 1 cycle with a..d = that digit and erro = 0; e.g. dot,dot,dash,dash,dash -> 0010.
REQ-033 The bench SHALL cover: dot,dash,dot,dash,dot -> ready = 1, erro = 1, a..d = 1111.
REQ-034 The bench SHALL cover backpressure: hold ack = 0 for 10 cycles with sym_valid = 1 -> sym_ready = 0 and outputs stable; after ack, the next symbol is accepted one cycle later.
REQ-035 The bench SHALL cover: reset pulse after 3 symbols, then a full pattern for 7 -> ready with 0111, no trace of the earlier symbols.
REQ-036 The bench SHALL cover, with DECODIFICADOR_TIMEOUT_EN and TIMEOUT = 4: 2 symbols, then 4 idle cycles -> one timeout pulse and IDLE; then dash×5 -> digit 0.
REQ-037 The bench SHALL cover, with DECODIFICADOR_TIMEOUT_EN: a symbol accepted exactly on the expiry cycle -> no timeout pulse and the character continues.
